// File: rtl/button_events.sv
// Press/release/short/long/auto-repeat event generator for a debounced button.
// The debounced level is resynchronised into clk, then timed in prescaled ticks.
module button_events #(
    parameter int TICK_DIV     = 1000,
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             debounced,
    output logic             held,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             short_press,
    output logic             long_press,
    output logic             repeat_pulse,
    output logic [CNT_W-1:0] hold_ticks
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0]    RPT_LAST   = RW'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_M1    = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [RW-1:0]    rpt_q, rpt_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic rise, fall, tick;

    // Edges are detected one stage early so the strobes land with the first
    // cycle of the new held level.
    assign rise = sync1_q & ~sync2_q;
    assign fall = ~sync1_q & sync2_q;
    // No tick in the press cycle itself, so TICK_DIV=1 still ticks first at P+1.
    assign tick = sync2_q & (presc_q == PRESC_LAST) & ~press_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            presc_q   <= '0;
            rpt_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= debounced;
            sync2_q   <= sync1_q;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            presc_q   <= presc_d;
            rpt_q     <= rpt_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        press_d   = rise;
        release_d = fall;
        short_d   = fall & (state_q != LONG);
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        presc_d   = presc_q;
        rpt_d     = rpt_q;
        hold_d    = hold_q;

        case (state_q)
            IDLE: begin
                if (press_q) state_d = PRESSED;
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (tick && hold_q == LONG_M1) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            LONG: begin
                if (!sync2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!sync2_q || press_q) begin
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (rise) begin
            hold_d = '0;
        end else if (tick && hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end

        // Repeat cadence runs on its own counter so it survives hold_ticks saturation.
        if (state_q != LONG) begin
            rpt_d = '0;
        end else if (tick) begin
            if (rpt_q == RPT_LAST) begin
                rpt_d    = '0;
                repeat_d = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
    end

    assign held          = sync2_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign hold_ticks    = hold_q;

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: two instances (16-bit and 4-bit hold counter) share
// stimulus and are compared every cycle against a timing model built from press time.
module tb_button_events;

    localparam int T  = 4;
    localparam int L  = 3;
    localparam int RT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        debounced;
    logic        held, press_pulse, release_pulse, short_press, long_press, repeat_pulse;
    logic [15:0] hold_ticks;
    logic        held4, press4, rel4, short4, long4, rep4;
    logic [3:0]  hold4;

    always #5 clk = ~clk;

    button_events #(.TICK_DIV(T), .LONG_TICKS(L), .REPEAT_TICKS(RT), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .debounced(debounced),
        .held(held), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .short_press(short_press), .long_press(long_press), .repeat_pulse(repeat_pulse),
        .hold_ticks(hold_ticks)
    );

    button_events #(.TICK_DIV(T), .LONG_TICKS(L), .REPEAT_TICKS(RT), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .debounced(debounced),
        .held(held4), .press_pulse(press4), .release_pulse(rel4),
        .short_press(short4), .long_press(long4), .repeat_pulse(rep4),
        .hold_ticks(hold4)
    );

    int  nvec = 0;
    int  nbad = 0;
    int  cyc  = 0;
    bit  r1 = 1'b1, r2 = 1'b1, r3 = 1'b1;
    bit  d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
    bit  in_press = 1'b0;
    int  m_p = 0;
    int  last16 = 0, last4 = 0;
    logic        e_held, e_press, e_rel, e_short, e_long, e_rep;
    logic [15:0] e_hold16;
    logic [3:0]  e_hold4;

    int  long_at;
    int  rep_q[$];
    int  rep4_q[$];

    function automatic logic [31:0] obs_vec();
        return {held, press_pulse, release_pulse, short_press, long_press, repeat_pulse, hold_ticks,
                held4, press4, rel4, short4, long4, rep4, hold4};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {e_held, e_press, e_rel, e_short, e_long, e_rep, e_hold16,
                e_held, e_press, e_rel, e_short, e_long, e_rep, e_hold4};
    endfunction

    // Expected outputs for cycle cyc, derived from the press cycle and elapsed time.
    function automatic void model();
        bit h, hp;
        int j, dd, k;
        h  = d2 && !r2 && !r1;
        hp = d3 && !r3 && !r2;
        {e_held, e_press, e_rel, e_short, e_long, e_rep} = '0;
        e_hold16 = '0;
        e_hold4  = '0;
        if (r1) begin
            in_press = 1'b0;
            last16   = 0;
            last4    = 0;
        end else begin
            e_held = h;
            if (h && !hp) begin
                m_p      = cyc;
                in_press = 1'b1;
                e_press  = 1'b1;
            end
            if (!h && hp) e_rel = 1'b1;
            if (in_press) begin
                j = (cyc == m_p) ? 0 : (cyc - 1 - m_p) / T;
                if (cyc > m_p) begin
                    dd = cyc - 1 - m_p;
                    if (dd % T == 0) begin
                        k = dd / T;
                        if (k == L) e_long = 1'b1;
                        if (k > L && (k - L) % RT == 0) e_rep = 1'b1;
                    end
                end
                last16 = (j > 65535) ? 65535 : j;
                last4  = (j > 15) ? 15 : j;
                if (!h) begin
                    e_short  = (cyc <= m_p + L * T + 1);
                    in_press = 1'b0;
                end
            end
            e_hold16 = 16'(last16);
            e_hold4  = 4'(last4);
        end
    endfunction

    task automatic step(input bit d, input bit r);
        debounced = d;
        reset     = r;
        @(negedge clk);
        cyc++;
        r3 = r2; r2 = r1; r1 = r;
        d3 = d2; d2 = d1; d1 = d;
        model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Raise the button, wait for the press, release so that held falls at p+len.
    task automatic run_press(input string nm, input int len, output int p);
        bit seen;
        int c0;
        seen    = 1'b0;
        c0      = cyc;
        long_at = -1;
        rep_q.delete();
        rep4_q.delete();
        for (int i = 0; i < 4 && !seen; i++) begin
            step(1'b1, 1'b0);
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nbad++;
                $display("FAIL %s_rise cyc=%0d got=%h exp=%h", nm, cyc, obs_vec(), exp_vec());
            end
            if (press_pulse === 1'b1) seen = 1'b1;
        end
        nvec++;
        if (!seen || cyc != c0 + 2 || hold_ticks !== 16'd0 || held !== 1'b1) begin
            nbad++;
            $display("FAIL %s_press_latency cyc=%0d got_seen=%0d hold=%0d exp_cyc=%0d hold=0", nm, cyc, seen, hold_ticks, c0 + 2);
        end
        p = cyc;
        while (cyc < p + len) begin
            step(cyc < p + len - 2, 1'b0);
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nbad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, obs_vec(), exp_vec());
            end
            if (long_press === 1'b1 && long_at < 0) long_at = cyc;
            if (repeat_pulse === 1'b1) rep_q.push_back(cyc);
            if (rep4 === 1'b1) rep4_q.push_back(cyc);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            step(i >= 3, 1'b1);
            nvec++;
            if (obs_vec() !== 32'h0 || obs_vec() !== exp_vec()) begin
                nbad++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nbad++;
                $display("FAIL reset_exit cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_short_press();
        int p;
        idle(3);
        run_press("short", 10, p);
        nvec++;
        if (hold_ticks !== 16'd2 || release_pulse !== 1'b1 || short_press !== 1'b1 || long_at >= 0) begin
            nbad++;
            $display("FAIL short_release hold=%0d rel=%b short=%b long_at=%0d exp hold=2 rel=1 short=1 no long",
                     hold_ticks, release_pulse, short_press, long_at);
        end
    endtask

    task automatic test_long_press();
        int p;
        idle(4);
        run_press("long", 35, p);
        nvec++;
        if (long_at != p + 13 || rep_q.size() < 2) begin
            nbad++;
            $display("FAIL long_timing long_at=%0d reps=%0d exp long_at=%0d reps>=2", long_at, rep_q.size(), p + 13);
        end else if (rep_q[0] != p + 21 || rep_q[1] != p + 29) begin
            nbad++;
            $display("FAIL repeat_timing got=%0d,%0d exp=%0d,%0d", rep_q[0], rep_q[1], p + 21, p + 29);
        end
        nvec++;
        if (release_pulse !== 1'b1 || short_press !== 1'b0 || hold_ticks !== 16'd8) begin
            nbad++;
            $display("FAIL long_release rel=%b short=%b hold=%0d exp rel=1 short=0 hold=8", release_pulse, short_press, hold_ticks);
        end
    endtask

    task automatic test_tick_release();
        int p;
        idle(4);
        run_press("tick_rel", 12, p);
        nvec++;
        if (hold_ticks !== 16'd2 || short_press !== 1'b1 || long_at >= 0 || long_press !== 1'b0) begin
            nbad++;
            $display("FAIL tick_release hold=%0d short=%b long_at=%0d exp hold=2 short=1 no long", hold_ticks, short_press, long_at);
        end
    endtask

    task automatic test_saturation();
        int p;
        int bad_gap;
        idle(4);
        run_press("sat", 330, p);
        bad_gap = 0;
        for (int i = 1; i < rep4_q.size(); i++) if (rep4_q[i] - rep4_q[i-1] != 8) bad_gap++;
        nvec++;
        if (hold4 !== 4'd15 || hold_ticks !== 16'd82 || rep4_q.size() != 39 || bad_gap != 0) begin
            nbad++;
            $display("FAIL saturation hold4=%0d hold16=%0d reps=%0d bad_gaps=%0d exp 15 82 39 0",
                     hold4, hold_ticks, rep4_q.size(), bad_gap);
        end
    endtask

    task automatic test_reset_mid_press();
        int  p, c1;
        bit  seen, stray;
        idle(4);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step(1'b1, 1'b0);
            if (press_pulse === 1'b1) seen = 1'b1;
        end
        p = cyc;
        while (cyc < p + 14) begin
            step(1'b1, 1'b0);
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nbad++;
                $display("FAIL rst_mid_hold cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        step(1'b1, 1'b1);
        nvec++;
        if (obs_vec() !== 32'h0 || obs_vec() !== exp_vec()) begin
            nbad++;
            $display("FAIL rst_mid_clear cyc=%0d got=%h exp=0", cyc, obs_vec());
        end
        c1    = cyc;
        seen  = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step(1'b1, 1'b0);
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nbad++;
                $display("FAIL rst_mid_after cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (release_pulse === 1'b1 || short_press === 1'b1) stray = 1'b1;
            if (press_pulse === 1'b1) seen = 1'b1;
        end
        nvec++;
        if (!seen || stray || cyc != c1 + 2 || hold_ticks !== 16'd0) begin
            nbad++;
            $display("FAIL rst_mid_repress cyc=%0d seen=%b stray=%b hold=%0d exp cyc=%0d seen=1 stray=0 hold=0",
                     cyc, seen, stray, hold_ticks, c1 + 2);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int  p;
        bit  seen;
        idle(4);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step(1'b1, 1'b0);
            if (press_pulse === 1'b1) seen = 1'b1;
        end
        p = cyc;
        while (cyc < p + 16) begin
            step(cyc != p + 7, 1'b0);
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nbad++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (cyc == p + 9) begin
                nvec++;
                if (release_pulse !== 1'b1 || short_press !== 1'b1 || hold_ticks !== 16'd2 || press_pulse !== 1'b0) begin
                    nbad++;
                    $display("FAIL b2b_release rel=%b short=%b hold=%0d exp rel=1 short=1 hold=2", release_pulse, short_press, hold_ticks);
                end
            end
            if (cyc == p + 10) begin
                nvec++;
                if (press_pulse !== 1'b1 || release_pulse !== 1'b0 || hold_ticks !== 16'd0) begin
                    nbad++;
                    $display("FAIL b2b_repress press=%b rel=%b hold=%0d exp press=1 rel=0 hold=0", press_pulse, release_pulse, hold_ticks);
                end
            end
            if (cyc == p + 15) begin
                nvec++;
                if (hold_ticks !== 16'd1) begin
                    nbad++;
                    $display("FAIL b2b_first_tick hold=%0d exp=1", hold_ticks);
                end
            end
        end
    endtask

    task automatic test_random();
        int left;
        bit lvl;
        bit rr;
        idle(4);
        left = 0;
        lvl  = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (left == 0) begin
                lvl  = ~lvl;
                left = $urandom_range(1, 45);
            end
            rr = ($urandom_range(0, 199) == 0);
            step(lvl, rr);
            left--;
            nvec++;
            if (obs_vec() !== exp_vec()) begin
                nbad++;
                $display("FAIL random cyc=%0d deb=%b rst=%b got=%h exp=%h", cyc, lvl, rr, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        debounced = 1'b0;
        test_reset();
        test_short_press();
        test_long_press();
        test_tick_release();
        test_saturation();
        test_reset_mid_press();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 Parameter TICK_DIV, default 1000: clk cycles per hold-time tick; SHALL be >= 1.
REQ-002 Parameter LONG_TICKS, default 500: ticks of continuous hold that make a long press; SHALL satisfy 1 <= LONG_TICKS < 2^CNT_W.
REQ-003 Parameter REPEAT_TICKS, default 100: ticks between auto-repeat pulses after a long press; SHALL be >= 1.
REQ-004 Parameter CNT_W, default 16: width of hold_ticks.
REQ-005 clk  in  1  sole clock; every register is clocked on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 debounced  in  1  debounced button level from the debounce stage; slow-clock domain, asynchronous to clk.
REQ-008 held  out  1  debounced level synchronized into the clk domain.
REQ-009 press_pulse  out  1  one-cycle strobe marking the start of a press.
REQ-010 release_pulse  out  1  one-cycle strobe marking the end of a press.
REQ-011 short_press  out  1  one-cycle strobe on release of a press that never reached LONG_TICKS.
REQ-012 long_press  out  1  one-cycle strobe when the hold reaches LONG_TICKS.
REQ-013 repeat_pulse  out  1  one-cycle auto-repeat strobe while a long press continues.
REQ-014 hold_ticks  out  CNT_W  saturating tick count of the current or most recent press.

Function
REQ-015 debounced SHALL pass through a 2-flop synchronizer; held = second flop, giving 2 clk cycles of latency.
REQ-016 Press cycle P is the first cycle with held=1; press_pulse SHALL be high in cycle P only.
REQ-017 Release cycle R is the first cycle with held=0 after a press; release_pulse SHALL be high in cycle R only.
REQ-018 The prescaler SHALL be loaded in cycle P so that it holds 0 in cycle P+1 and counts 0..TICK_DIV-1, wrapping.
REQ-019 A tick SHALL occur in each cycle where prescaler == TICK_DIV-1 and held=1; the first tick therefore falls at cycle P+TICK_DIV, and later ticks follow every TICK_DIV cycles.
REQ-020 hold_ticks SHALL load 0 in cycle P, increment by 1 after each tick, saturate at 2^CNT_W-1, and hold its value after release until the next press.
REQ-021 FSM states SHALL be IDLE, PRESSED and LONG. IDLE->PRESSED on press; PRESSED->LONG on the tick that brings hold_ticks to LONG_TICKS; PRESSED or LONG->IDLE on release.
REQ-022 long_press SHALL be high for one cycle, in the first cycle where hold_ticks reads LONG_TICKS.
REQ-023 In LONG, a separate repeat counter (independent of hold_ticks saturation) SHALL count ticks; repeat_pulse SHALL fire, registered, one cycle after each REPEAT_TICKS-th tick following the long-press tick.
REQ-024 short_press SHALL be high in cycle R if and only if the state in the cycle before R was PRESSED; no event other than release_pulse fires on release from LONG.
REQ-025 A tick and a release that would coincide SHALL resolve as release: held=0 blocks the tick, so short_press fires and long_press does not.
REQ-026 A press arriving in the cycle immediately after a release SHALL be handled as a new press per REQ-016 and REQ-018.
REQ-027 At most one of press_pulse or release_pulse SHALL be high in any cycle; long_press and repeat_pulse SHALL never coincide.

Reset
REQ-028 While reset=1: synchronizer flops, held, all strobes, hold_ticks, prescaler and repeat counter SHALL be 0, and the state SHALL be IDLE.
REQ-029 Reset asserted mid-press SHALL abort the press with no short_press or release_pulse. If debounced is still high afterwards, press_pulse SHALL fire 2 cycles after reset deasserts.

Verification (TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2, CNT_W=16 unless stated)
REQ-030 Raise debounced before clk edge k -> held=1 and press_pulse=1 in cycle k+2 only; hold_ticks=0.
REQ-031 Release at cycle P+10 -> hold_ticks=2, release_pulse=1 and short_press=1 in cycle P+10; long_press never fires.
REQ-032 Hold continuously -> long_press at P+13 (hold_ticks=3); repeat_pulse at P+21 and P+29; release -> release_pulse only, short_press=0.
REQ-033 Release exactly at cycle P+12 (third tick cycle) -> hold_ticks stays 2, short_press=1, long_press=0.
REQ-034 CNT_W=4, hold 80 ticks -> hold_ticks saturates at 15; repeat_pulse continues every 8 cycles.
REQ-035 Assert reset at P+14 with debounced high -> all outputs 0, no release or short strobe; after deassertion, press_pulse fires again 2 cycles later with hold_ticks=0.
